// File: rtl/rf_pkg.sv
// Shared defaults and storage type for the banked register file.
// Banks with non-default geometry declare the same packed shape locally.
package rf_pkg;

  localparam int RF_WIDTH  = 8;
  localparam int RF_DEPTH  = 4;
  localparam int RF_NUM_RD = 2;

  // One bank: entry r occupies [r][WIDTH-1:0].
  typedef logic [RF_DEPTH-1:0][RF_WIDTH-1:0] rf_array_t;

endpackage

// File: rtl/register_file_banked_if.sv
// Decode/writeback-side bus of the banked register file.
// Addresses and write controls are sampled at posedge clk.
// Timing contract (there is no valid/ready handshake): every cycle is a
// transaction. rd_data is the value of the addressed registers after that
// same edge's writes and restores, and it is visible from the edge onward.
// restore_err is a one-cycle pulse that follows a restore of an empty shadow.
interface register_file_banked_if
  import rf_pkg::*;
#(
  parameter int WIDTH  = RF_WIDTH,
  parameter int DEPTH  = RF_DEPTH,
  parameter int NUM_RD = RF_NUM_RD
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*WIDTH-1:0]  rd_data;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [WIDTH-1:0]         wr_data;
  logic                     save;
  logic                     restore;
  logic                     shadow_valid;
  logic                     restore_err;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, save, restore,
    input  rd_data, shadow_valid, restore_err
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, save, restore,
    output rd_data, shadow_valid, restore_err
  );

endinterface

// File: rtl/rf_bank.sv
// DEPTH x WIDTH register bank with a whole-array load and one write port.
// A same-cycle write lands on top of a load; entry 0 can be tied to zero.
module rf_bank
  import rf_pkg::*;
#(
  parameter  int WIDTH    = RF_WIDTH,
  parameter  int DEPTH    = RF_DEPTH,
  parameter  int ZERO_REG = 0,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load_en_i,
  input  logic [DEPTH-1:0][WIDTH-1:0]  load_data_i,
  input  logic                         wr_en_i,
  input  logic [ADDR_W-1:0]            wr_addr_i,
  input  logic [WIDTH-1:0]             wr_data_i,
  output logic [DEPTH-1:0][WIDTH-1:0]  data_o
);

  typedef logic [DEPTH-1:0][WIDTH-1:0] bank_t;

  bank_t data_q;
  bank_t data_d;

  always_comb begin
    data_d = data_q;
    if (load_en_i) data_d = load_data_i;
    if (wr_en_i) data_d[wr_addr_i] = wr_data_i;
    if (ZERO_REG != 0) data_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/register_file_banked.sv
// Multi-port register file with write-first registered reads and a single
// shadow bank for save/restore around context switches.
module register_file_banked
  import rf_pkg::*;
#(
  parameter int WIDTH    = RF_WIDTH,
  parameter int DEPTH    = RF_DEPTH,
  parameter int NUM_RD   = RF_NUM_RD,
  parameter int ZERO_REG = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  register_file_banked_if.slave bus
);

  localparam int ADDR_W = $clog2(DEPTH);

  typedef logic [DEPTH-1:0][WIDTH-1:0] bank_t;

  bank_t main_q;
  bank_t shadow_q;

  logic restore_ok;
  logic shadow_load;

  logic [NUM_RD*WIDTH-1:0] rd_data_q;
  logic [NUM_RD*WIDTH-1:0] rd_data_d;
  logic                    shadow_valid_q;
  logic                    shadow_valid_d;
  logic                    restore_err_q;
  logic                    restore_err_d;

  logic [ADDR_W-1:0] rd_sel;
  logic [WIDTH-1:0]  rd_word;

  // Restore wins over save, so the shadow only loads on a lone save.
  assign restore_ok  = bus.restore && shadow_valid_q;
  assign shadow_load = bus.save && !bus.restore;

  rf_bank #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .ZERO_REG(ZERO_REG)
  ) u_main (
    .clk        (clk),
    .reset      (reset),
    .load_en_i  (restore_ok),
    .load_data_i(shadow_q),
    .wr_en_i    (bus.wr_en),
    .wr_addr_i  (bus.wr_addr),
    .wr_data_i  (bus.wr_data),
    .data_o     (main_q)
  );

  rf_bank #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .ZERO_REG(ZERO_REG)
  ) u_shadow (
    .clk        (clk),
    .reset      (reset),
    .load_en_i  (shadow_load),
    .load_data_i(main_q),
    .wr_en_i    (1'b0),
    .wr_addr_i  ('0),
    .wr_data_i  ('0),
    .data_o     (shadow_q)
  );

  // Each port sees the value main will hold after this edge:
  // hardwired zero, then the incoming write, then a restored word.
  always_comb begin
    rd_data_d = '0;
    rd_sel    = '0;
    rd_word   = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_sel = bus.rd_addr[i*ADDR_W +: ADDR_W];
      if (ZERO_REG != 0 && rd_sel == '0) begin
        rd_word = '0;
      end else if (bus.wr_en && bus.wr_addr == rd_sel) begin
        rd_word = bus.wr_data;
      end else if (restore_ok) begin
        rd_word = shadow_q[rd_sel];
      end else begin
        rd_word = main_q[rd_sel];
      end
      rd_data_d[i*WIDTH +: WIDTH] = rd_word;
    end
  end

  always_comb begin
    shadow_valid_d = shadow_valid_q;
    restore_err_d  = bus.restore && !shadow_valid_q;
    if (bus.restore) begin
      if (!bus.save) shadow_valid_d = 1'b0;
    end else if (bus.save) begin
      shadow_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_data_q      <= '0;
      shadow_valid_q <= 1'b0;
      restore_err_q  <= 1'b0;
    end else begin
      rd_data_q      <= rd_data_d;
      shadow_valid_q <= shadow_valid_d;
      restore_err_q  <= restore_err_d;
    end
  end

  assign bus.rd_data      = rd_data_q;
  assign bus.shadow_valid = shadow_valid_q;
  assign bus.restore_err  = restore_err_q;

endmodule

// File: doc/register_file_banked.md
Name: register_file_banked

Overview:
- Parametrised next-generation register file: configurable data width, depth and read-port count.
- Read data is registered on the rising edge of clk with write-first forwarding, so a read in the same cycle as a write to the same register returns the new value.
- Adds a single shadow bank with save/restore for context switches or interrupt entry and exit, plus an optional hardwired-zero register 0.
- Sits between instruction decode (addresses) and the ALU/writeback path.

Parameters:
- WIDTH, 8, data width in bits.
- DEPTH, 4, number of architectural registers; must be a power of 2 and at least 2.
- NUM_RD, 2, number of read ports (1..4).
- ZERO_REG, 0, when 1 register 0 always reads 0 and ignores writes and restores.
- ADDR_W, $clog2(DEPTH), derived localparam, not overridable.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-low; state is cleared on the posedge clk where reset==0.
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*WIDTH  packed registered read data, same packing.
- wr_en  in  1  write enable.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  WIDTH  write data.
- save  in  1  copy the whole main bank into the shadow bank.
- restore  in  1  copy the whole shadow bank into the main bank.
- shadow_valid  out  1  shadow bank holds a saved context.
- restore_err  out  1  one-cycle pulse: restore requested while shadow_valid==0.

Behaviour:
- Reset (reset==0 at posedge):
  - All main and shadow registers are set to 0.
  - rd_data, shadow_valid and restore_err are 0.
  - Reset overrides every other input that cycle.
- Per-cycle update order (single posedge). Define next_main as:
  1. Start from current main.
  2. If restore and shadow_valid, replace it with shadow.
  3. If wr_en, overwrite entry wr_addr with wr_data.
  4. If ZERO_REG, force entry 0 to 0.
- main <= next_main.
- Read latency is 1 cycle: rd_data port i <= next_main[rd_addr i]. Write-first forwarding follows from this, including forwarding of restored values.
- Save:
  - shadow <= current main, i.e. the value before any same-cycle write. A same-cycle write does not enter the shadow.
  - shadow_valid <= 1.
- Save and restore asserted together:
  - Restore has priority; save is ignored that cycle.
  - shadow_valid stays 1 if it was 1.
- Restore with shadow_valid==1:
  - Main is loaded from shadow as above.
  - shadow_valid <= 0, making restore one-shot.
- Restore with shadow_valid==0:
  - Main is unchanged, apart from any same-cycle write.
  - restore_err <= 1 for exactly one cycle.
- restore_err otherwise <= 0.
- Addresses always lie in range because DEPTH is a power of 2; no wrap handling is needed.
- Any number of read ports may address the same register; there is no conflict.

Decomposition:
- Package rf_pkg: default WIDTH and DEPTH constants, and a typedef for the packed register-array type used for both banks.
- Sub-module rf_bank: a DEPTH x WIDTH storage array with a whole-array load port and a single write port.
  - Instantiated twice, as main and shadow.
  - The read mux and control logic stay in the top module.

Test Plan:
- Reset and write-back: hold reset=0 for 2 cycles, then set reset=1 and write R1=0xA5. Next cycle read R1 on port 0 -> rd_data port 0 = 0xA5; all other registers read 0x00.
- Same-cycle forwarding: wr_en=1, wr_addr=2, wr_data=0x3C with rd_addr port 1 = 2 in the same cycle -> after one posedge, rd_data port 1 = 0x3C.
- Save, then restore:
  - With R0..R3 = 11,22,33,44, pulse save together with write R3=0x55. Shadow must hold 44 for R3.
  - Write R0..R3 = 0xFF, then pulse restore. Reads give 11,22,33,44 and shadow_valid goes to 0.
- Restore with empty shadow: after reset, pulse restore -> restore_err high for exactly 1 cycle and main unchanged. Repeat together with a write R1=0x07 -> R1 reads 0x07.
- Simultaneous save and restore with shadow_valid==1:
  - Main is restored.
  - shadow_valid stays 1.
  - The shadow contents are unchanged (check with a second restore).
- ZERO_REG=1 with DEPTH=8, WIDTH=16: write R0=0xBEEF -> R0 reads 0x0000. Then write R7=0xBEEF -> R7 reads 0xBEEF.
